// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, stall
// encoding, load-op codes and packed views of the pipeline buses.
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD = 76;
    localparam int MEM_TO_WB_WD = 70;
    localparam int HILO_WD      = 66;
    localparam int STALL_BUS_WD = 6;

    // Stall vector encoding and the bit positions this stage cares about.
    localparam logic STOP      = 1'b1;
    localparam logic NO_STOP   = 1'b0;
    localparam int   STALL_MEM = 3;
    localparam int   STALL_WB  = 4;

    typedef enum logic [2:0] {
        LD_LW  = 3'd0,
        LD_LB  = 3'd1,
        LD_LBU = 3'd2,
        LD_LH  = 3'd3,
        LD_LHU = 3'd4
    } ld_op_e;

    // Field view of the execute-to-memory bus (MSB first).
    typedef struct packed {
        logic [31:0] pc;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] result;
    } ex_to_mem_t;

    // Field view of the HI/LO bus (MSB first).
    typedef struct packed {
        logic [31:0] hi_wdata;
        logic [31:0] lo_wdata;
        logic        hi_we;
        logic        lo_we;
    } hilo_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load alignment: picks the addressed byte/half out of a 32-bit SRAM word
// and sign- or zero-extends it. Purely combinational.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  i_ld_op,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte and half-word; half uses only off[1].
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_byte = i_rdata[7:0];
        case (i_off)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Extend according to the load type; unknown codes behave as lw.
    always_comb begin
        o_data = i_rdata;
        case (i_ld_op)
            LD_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            LD_LBU:  o_data = {24'd0, w_byte};
            LD_LH:   o_data = {{16{w_half[15]}}, w_half};
            LD_LHU:  o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the EX->MEM, HI/LO and load-op
// inputs, aligns SRAM load data, selects writeback data and drives the
// MEM->WB buses plus forwarding outputs. SRAM read data is latched on the
// first stalled cycle so a long stall cannot lose it.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_BUS_WD-1:0] stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [2:0]              ex_ld_op,
    input  logic [HILO_WD-1:0]      hilo_ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [HILO_WD-1:0]      hilo_mem_to_wb_bus,
    output logic                    mem_wreg,
    output logic [4:0]              mem_waddr,
    output logic [31:0]             mem_wdata,
    output logic                    mem_hi_we,
    output logic                    mem_lo_we,
    output logic [31:0]             mem_hi_wdata,
    output logic [31:0]             mem_lo_wdata
);

    ex_to_mem_t  r_bus;
    logic [2:0]  r_ld_op;
    hilo_t       r_hilo;
    logic [31:0] r_hold_data;
    logic        r_hold_valid;

    logic        w_stop_mem;
    logic        w_bubble;
    logic        w_load;
    logic        w_is_read;
    logic [31:0] w_rdata_eff;
    logic [31:0] w_load_data;
    logic [31:0] w_rf_wdata;
    logic        w_unused_stall;

    assign w_stop_mem = (stall[STALL_MEM] == STOP);
    assign w_bubble   = w_stop_mem && (stall[STALL_WB] == NO_STOP);
    assign w_load     = !w_stop_mem;
    assign w_is_read  = r_bus.ram_en && (r_bus.ram_wen == 4'd0);

    // Only the MEM and WB stall bits matter to this stage.
    assign w_unused_stall = ^{stall[STALL_BUS_WD-1:STALL_WB+1], stall[STALL_MEM-1:0]};

    // Pipeline register: reset, then bubble, then load; otherwise hold.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            r_bus   <= '0;
            r_ld_op <= '0;
            r_hilo  <= '0;
        end else if (w_bubble) begin
            r_bus   <= '0;
            r_ld_op <= '0;
            r_hilo  <= '0;
        end else if (w_load) begin
            r_bus   <= ex_to_mem_t'(ex_to_mem_bus);
            r_ld_op <= ex_ld_op;
            r_hilo  <= hilo_t'(hilo_ex_to_mem_bus);
        end
    end

    // Read-hold buffer: capture SRAM data on the first stalled cycle of a load.
    always_ff @(posedge clk) begin
        if (rst || w_bubble || w_load) begin
            r_hold_data  <= '0;
            r_hold_valid <= 1'b0;
        end else if (w_stop_mem && !r_hold_valid && w_is_read) begin
            r_hold_data  <= data_sram_rdata;
            r_hold_valid <= 1'b1;
        end
    end

    assign w_rdata_eff = r_hold_valid ? r_hold_data : data_sram_rdata;

    mem_stage_load_align u_load_align (
        .i_ld_op (r_ld_op),
        .i_off   (r_bus.result[1:0]),
        .i_rdata (w_rdata_eff),
        .o_data  (w_load_data)
    );

    assign w_rf_wdata = r_bus.sel_rf_res ? w_load_data : r_bus.result;

    assign mem_to_wb_bus      = {r_bus.pc, r_bus.rf_we, r_bus.rf_waddr, w_rf_wdata};
    assign hilo_mem_to_wb_bus = r_hilo;

    assign mem_wreg     = r_bus.rf_we;
    assign mem_waddr    = r_bus.rf_waddr;
    assign mem_wdata    = w_rf_wdata;
    assign mem_hi_we    = r_hilo.hi_we;
    assign mem_lo_we    = r_hilo.lo_we;
    assign mem_hi_wdata = r_hilo.hi_wdata;
    assign mem_lo_wdata = r_hilo.lo_wdata;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a driver applies one vector per cycle and queues the
// outputs expected for that cycle; a negedge monitor pops and compares.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [75:0] ex_to_mem_bus;
    logic [2:0]  ex_ld_op;
    logic [65:0] hilo_ex_to_mem_bus;
    logic [31:0] data_sram_rdata;
    logic [69:0] mem_to_wb_bus;
    logic [65:0] hilo_mem_to_wb_bus;
    logic        mem_wreg;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_hi_we;
    logic        mem_lo_we;
    logic [31:0] mem_hi_wdata;
    logic [31:0] mem_lo_wdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [69:0] wb;
        logic [65:0] hl;
        bit          chk_hv;
        logic        hv;
    } exp_t;

    exp_t sb[$];

    localparam logic [5:0] ST_NONE = 6'b000000;
    localparam logic [5:0] ST_HOLD = 6'b011000;
    localparam logic [5:0] ST_BUB  = 6'b001000;

    mem_stage dut (
        .clk                (clk),
        .rst                (rst),
        .stall              (stall),
        .ex_to_mem_bus      (ex_to_mem_bus),
        .ex_ld_op           (ex_ld_op),
        .hilo_ex_to_mem_bus (hilo_ex_to_mem_bus),
        .data_sram_rdata    (data_sram_rdata),
        .mem_to_wb_bus      (mem_to_wb_bus),
        .hilo_mem_to_wb_bus (hilo_mem_to_wb_bus),
        .mem_wreg           (mem_wreg),
        .mem_waddr          (mem_waddr),
        .mem_wdata          (mem_wdata),
        .mem_hi_we          (mem_hi_we),
        .mem_lo_we          (mem_lo_we),
        .mem_hi_wdata       (mem_hi_wdata),
        .mem_lo_wdata       (mem_lo_wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [75:0] mk_ex(input logic [31:0] pc, input logic en,
                                          input logic [3:0] wen, input logic sel,
                                          input logic we, input logic [4:0] wa,
                                          input logic [31:0] res);
        return {pc, en, wen, sel, we, wa, res};
    endfunction

    function automatic logic [69:0] mk_wb(input logic [31:0] pc, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
        return {pc, we, wa, wd};
    endfunction

    function automatic logic [65:0] mk_hl(input logic [31:0] hi, input logic [31:0] lo,
                                          input logic hwe, input logic lwe);
        return {hi, lo, hwe, lwe};
    endfunction

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply this cycle's inputs, queue the outputs expected this cycle, advance.
    task automatic step(input string name, input logic r, input logic [5:0] st,
                        input logic [75:0] ex, input logic [2:0] ld, input logic [65:0] hl,
                        input logic [31:0] rd, input logic [69:0] e_wb,
                        input logic [65:0] e_hl, input bit chk_hv, input logic e_hv);
        exp_t e;
        rst                = r;
        stall              = st;
        ex_to_mem_bus      = ex;
        ex_ld_op           = ld;
        hilo_ex_to_mem_bus = hl;
        data_sram_rdata    = rd;
        e.name   = name;
        e.wb     = e_wb;
        e.hl     = e_hl;
        e.chk_hv = chk_hv;
        e.hv     = e_hv;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every queued expectation against the DUT mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "/wb_bus"},    mem_to_wb_bus,             e.wb);
            check({e.name, "/hilo_bus"},  70'(hilo_mem_to_wb_bus),   70'(e.hl));
            check({e.name, "/wreg"},      70'(mem_wreg),             70'(e.wb[37]));
            check({e.name, "/waddr"},     70'(mem_waddr),            70'(e.wb[36:32]));
            check({e.name, "/wdata"},     70'(mem_wdata),            70'(e.wb[31:0]));
            check({e.name, "/hi_we"},     70'(mem_hi_we),            70'(e.hl[1]));
            check({e.name, "/lo_we"},     70'(mem_lo_we),            70'(e.hl[0]));
            check({e.name, "/hi_wdata"},  70'(mem_hi_wdata),         70'(e.hl[65:34]));
            check({e.name, "/lo_wdata"},  70'(mem_lo_wdata),         70'(e.hl[33:2]));
            if (e.chk_hv)
                check({e.name, "/hold_valid"}, 70'(dut.r_hold_valid), 70'(e.hv));
        end
    end

    initial begin
        logic [75:0] ex_n;
        logic [75:0] ex_ldw;
        logic [65:0] hl_a;
        logic [65:0] hl_b;
        logic [31:0] rd0;

        rd0    = 32'h80FF7F01;
        ex_n   = mk_ex(32'h124, 1'b0, 4'h0, 1'b0, 1'b1, 5'd16, 32'h0000_9999);
        ex_ldw = mk_ex(32'h134, 1'b1, 4'h0, 1'b1, 1'b1, 5'd19, 32'h0000_0000);
        hl_a   = mk_hl(32'hAAAA0000, 32'h00005555, 1'b1, 1'b0);
        hl_b   = mk_hl(32'h11112222, 32'h33334444, 1'b1, 1'b1);

        // First reset cycle with random inputs (no expectation before the first edge).
        rst                = 1'b1;
        stall              = 6'($urandom);
        ex_to_mem_bus      = {12'($urandom), $urandom, $urandom};
        ex_ld_op           = 3'($urandom);
        hilo_ex_to_mem_bus = {2'($urandom), $urandom, $urandom};
        data_sram_rdata    = $urandom;
        @(posedge clk);
        #1;

        step("reset1", 1'b1, 6'($urandom), {12'($urandom), $urandom, $urandom}, 3'($urandom),
             {2'($urandom), $urandom, $urandom}, $urandom, '0, '0, 1'b1, 1'b0);
        step("reset2", 1'b0, ST_NONE,
             mk_ex(32'h100, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'h1234_5678), LD_LW, '0,
             $urandom, '0, '0, 1'b1, 1'b0);
        step("alu_pass", 1'b0, ST_NONE,
             mk_ex(32'h104, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9, 32'h0000_1003), LD_LB, '0,
             32'h0, mk_wb(32'h100, 1'b1, 5'd8, 32'h1234_5678), '0, 1'b0, 1'b0);
        step("lb_off3", 1'b0, ST_NONE,
             mk_ex(32'h108, 1'b1, 4'h0, 1'b1, 1'b1, 5'd10, 32'h0000_2007), LD_LBU, '0,
             rd0, mk_wb(32'h104, 1'b1, 5'd9, 32'hFFFF_FF80), '0, 1'b0, 1'b0);
        step("lbu_off3", 1'b0, ST_NONE,
             mk_ex(32'h10C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd11, 32'h0000_3002), LD_LH, '0,
             rd0, mk_wb(32'h108, 1'b1, 5'd10, 32'h0000_0080), '0, 1'b0, 1'b0);
        step("lh_off2", 1'b0, ST_NONE,
             mk_ex(32'h110, 1'b1, 4'h0, 1'b1, 1'b1, 5'd12, 32'h0000_4000), LD_LHU, '0,
             rd0, mk_wb(32'h10C, 1'b1, 5'd11, 32'hFFFF_80FF), '0, 1'b0, 1'b0);
        step("lhu_off0", 1'b0, ST_NONE,
             mk_ex(32'h114, 1'b1, 4'h0, 1'b1, 1'b1, 5'd13, 32'h0000_5000), LD_LW, '0,
             rd0, mk_wb(32'h110, 1'b1, 5'd12, 32'h0000_7F01), '0, 1'b0, 1'b0);
        step("lw", 1'b0, ST_NONE,
             mk_ex(32'h118, 1'b1, 4'h0, 1'b1, 1'b1, 5'd14, 32'h0000_6003), LD_LH, '0,
             rd0, mk_wb(32'h114, 1'b1, 5'd13, 32'h80FF_7F01), '0, 1'b0, 1'b0);
        step("lh_off3", 1'b0, ST_NONE,
             mk_ex(32'h11C, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h0000_7000), LD_LW, '0,
             rd0, mk_wb(32'h118, 1'b1, 5'd14, 32'hFFFF_80FF), '0, 1'b0, 1'b0);
        step("store", 1'b0, ST_NONE,
             mk_ex(32'h120, 1'b1, 4'h0, 1'b1, 1'b1, 5'd15, 32'h0000_8000), 3'd7, '0,
             32'h55AA_55AA, mk_wb(32'h11C, 1'b0, 5'd0, 32'h0000_7000), '0, 1'b0, 1'b0);

        // Stall hold: load (odd op code -> lw) sees DEADBEEF, then SRAM data drops to zero.
        step("hold_c0", 1'b0, ST_HOLD, ex_n, LD_LW, '0, 32'hDEAD_BEEF,
             mk_wb(32'h120, 1'b1, 5'd15, 32'hDEAD_BEEF), '0, 1'b1, 1'b0);
        step("hold_c1", 1'b0, ST_HOLD, ex_n, LD_LW, '0, 32'h0,
             mk_wb(32'h120, 1'b1, 5'd15, 32'hDEAD_BEEF), '0, 1'b1, 1'b1);
        step("hold_c2", 1'b0, ST_HOLD, ex_n, LD_LW, '0, 32'h0,
             mk_wb(32'h120, 1'b1, 5'd15, 32'hDEAD_BEEF), '0, 1'b1, 1'b1);
        step("hold_rel", 1'b0, ST_NONE, ex_n, LD_LW, '0, 32'h0,
             mk_wb(32'h120, 1'b1, 5'd15, 32'hDEAD_BEEF), '0, 1'b1, 1'b1);
        step("after_rel", 1'b0, ST_NONE,
             mk_ex(32'h128, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h0), LD_LW, hl_a, 32'h0,
             mk_wb(32'h124, 1'b1, 5'd16, 32'h0000_9999), '0, 1'b1, 1'b0);

        // HI/LO pass-through, then a bubble on the following op.
        step("hilo", 1'b0, ST_BUB,
             mk_ex(32'h12C, 1'b0, 4'h0, 1'b0, 1'b1, 5'd17, 32'h0000_1111), LD_LW, hl_b, 32'h0,
             mk_wb(32'h128, 1'b0, 5'd0, 32'h0), hl_a, 1'b0, 1'b0);
        step("bubble", 1'b0, ST_NONE,
             mk_ex(32'h130, 1'b0, 4'h0, 1'b0, 1'b1, 5'd18, 32'h0000_CAFE), LD_LW, '0, 32'h0,
             '0, '0, 1'b1, 1'b0);
        step("post_bub", 1'b0, ST_NONE, '0, LD_LW, '0, 32'h0,
             mk_wb(32'h130, 1'b1, 5'd18, 32'h0000_CAFE), '0, 1'b0, 1'b0);

        // Reset during a stall with captured load data.
        step("idle", 1'b0, ST_NONE, ex_ldw, LD_LW, '0, 32'h0, '0, '0, 1'b0, 1'b0);
        step("rs_stall", 1'b0, ST_HOLD, ex_ldw, LD_LW, '0, 32'h0BAD_F00D,
             mk_wb(32'h134, 1'b1, 5'd19, 32'h0BAD_F00D), '0, 1'b1, 1'b0);
        step("rs_assert", 1'b1, ST_HOLD, ex_ldw, LD_LW, '0, 32'h0,
             mk_wb(32'h134, 1'b1, 5'd19, 32'h0BAD_F00D), '0, 1'b1, 1'b1);
        step("rs_clear", 1'b0, ST_NONE,
             mk_ex(32'h138, 1'b0, 4'h0, 1'b0, 1'b1, 5'd20, 32'h0000_0077), LD_LW, '0, 32'h12,
             '0, '0, 1'b1, 1'b0);
        step("rs_resume", 1'b0, ST_NONE, '0, LD_LW, '0, 32'h0,
             mk_wb(32'h138, 1'b1, 5'd20, 32'h0000_0077), '0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
